// File: rtl/alu_exec_unit.sv
// alu_exec_unit: EX-stage ALU decode/execute, PC adders and a stall-aware result register
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic [9:0]       funct_i,
  input  logic [1:0]       ALUOp_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic [2:0]       ALUCtrl_o,
  output logic [WIDTH-1:0] data_o,
  output logic             Zero_o,
  output logic [WIDTH-1:0] result_q_o,
  output logic             zero_q_o,
  input  logic [WIDTH-1:0] pc_i,
  output logic [WIDTH-1:0] pc_plus4_o,
  input  logic [WIDTH-1:0] pc_id_i,
  input  logic [WIDTH-1:0] imm_i,
  output logic [WIDTH-1:0] branch_target_o
);
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_XOR = 3'b001;
  localparam logic [2:0] OP_SLL = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SRA = 3'b110;

  logic [2:0] r_ctrl;
  logic [2:0] i_ctrl;

  // decode: R-type by full funct, I-type by funct3, unmatched patterns fall back to ADD
  always_comb begin
    r_ctrl = funct_i == 10'b0000000_111 ? OP_AND :
             funct_i == 10'b0000000_100 ? OP_XOR :
             funct_i == 10'b0000000_001 ? OP_SLL :
             funct_i == 10'b0100000_000 ? OP_SUB :
             funct_i == 10'b0000001_000 ? OP_MUL : OP_ADD;
    i_ctrl = funct_i[2:0] == 3'b101 ? OP_SRA : OP_ADD;
    ALUCtrl_o = ALUOp_i == 2'b00 ? OP_ADD :
                ALUOp_i == 2'b01 ? OP_SUB :
                ALUOp_i == 2'b10 ? r_ctrl : i_ctrl;
  end

  // execute: shift amount is the low five bits of operand B, code 111 yields zero
  always_comb begin
    data_o = ALUCtrl_o == OP_AND ? data1_i & data2_i :
             ALUCtrl_o == OP_XOR ? data1_i ^ data2_i :
             ALUCtrl_o == OP_SLL ? data1_i << data2_i[4:0] :
             ALUCtrl_o == OP_ADD ? data1_i + data2_i :
             ALUCtrl_o == OP_SUB ? data1_i - data2_i :
             ALUCtrl_o == OP_MUL ? data1_i * data2_i :
             ALUCtrl_o == OP_SRA ? WIDTH'($signed(data1_i) >>> data2_i[4:0]) : '0;
    Zero_o = data_o == '0;
  end

  assign pc_plus4_o      = pc_i + WIDTH'(4);
  assign branch_target_o = pc_id_i + (imm_i << 1);

  // EX/MEM result register, frozen while the cache stalls the pipe
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      result_q_o <= '0;
      zero_q_o   <= 1'b0;
    end else if (!stall_i) begin
      result_q_o <= data_o;
      zero_q_o   <= Zero_o;
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: table-driven ALU/decode vectors plus register, stall and reset sequences
module tb_alu_exec_unit;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        stall_i = 1'b0;
  logic [9:0]  funct_i = '0;
  logic [1:0]  ALUOp_i = '0;
  logic [31:0] data1_i = '0, data2_i = '0;
  logic [2:0]  ALUCtrl_o;
  logic [31:0] data_o, result_q_o, pc_plus4_o, branch_target_o;
  logic        Zero_o, zero_q_o;
  logic [31:0] pc_i = '0, pc_id_i = '0, imm_i = '0;

  int checks = 0;
  int errors = 0;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .funct_i(funct_i), .ALUOp_i(ALUOp_i),
    .data1_i(data1_i), .data2_i(data2_i), .ALUCtrl_o(ALUCtrl_o), .data_o(data_o), .Zero_o(Zero_o),
    .result_q_o(result_q_o), .zero_q_o(zero_q_o), .pc_i(pc_i), .pc_plus4_o(pc_plus4_o),
    .pc_id_i(pc_id_i), .imm_i(imm_i), .branch_target_o(branch_target_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  op;
    logic [9:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ctrl;
    logic [31:0] res;
    logic        zero;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc_id;
    logic [31:0] imm;
    logic [31:0] plus4;
    logic [31:0] target;
  } pc_vec_t;

  vec_t    vecs[14];
  pc_vec_t pcs[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [1:0] op, input logic [9:0] f, input logic [31:0] a, input logic [31:0] b);
    ALUOp_i = op;
    funct_i = f;
    data1_i = a;
    data2_i = b;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    vecs[0]  = '{2'b10, 10'b0100000_000, 32'h5,        32'h7,        3'b100, 32'hFFFFFFFE, 1'b0};
    vecs[1]  = '{2'b11, 10'b0100000_101, 32'h80000000, 32'h4,        3'b110, 32'hF8000000, 1'b0};
    vecs[2]  = '{2'b10, 10'b0000001_000, 32'h10000,    32'h10000,    3'b101, 32'h0,        1'b1};
    vecs[3]  = '{2'b01, 10'b0000000_000, 32'h1234,     32'h1234,     3'b100, 32'h0,        1'b1};
    vecs[4]  = '{2'b00, 10'b0000000_000, 32'h100,      32'hFFFFFFFC, 3'b011, 32'hFC,       1'b0};
    vecs[5]  = '{2'b10, 10'b0000000_111, 32'hF0F0,     32'hFF00,     3'b000, 32'hF000,     1'b0};
    vecs[6]  = '{2'b10, 10'b0000000_100, 32'hF0F0,     32'hFF00,     3'b001, 32'h0FF0,     1'b0};
    vecs[7]  = '{2'b10, 10'b0000000_001, 32'h1,        32'h21,       3'b010, 32'h2,        1'b0};
    vecs[8]  = '{2'b10, 10'b0000000_000, 32'h7,        32'hFFFFFFF9, 3'b011, 32'h0,        1'b1};
    vecs[9]  = '{2'b10, 10'b1111111_111, 32'h2,        32'h3,        3'b011, 32'h5,        1'b0};
    vecs[10] = '{2'b11, 10'b0000000_010, 32'h3,        32'h4,        3'b011, 32'h7,        1'b0};
    vecs[11] = '{2'b10, 10'b0000000_101, 32'h1,        32'h1,        3'b011, 32'h2,        1'b0};
    vecs[12] = '{2'b11, 10'b0000000_101, 32'h70000000, 32'h24,       3'b110, 32'h07000000, 1'b0};
    vecs[13] = '{2'b10, 10'b0000001_000, 32'h12345,    32'h10,       3'b101, 32'h123450,   1'b0};
    pcs[0] = '{32'hFFFFFFFC, 32'h40,       32'hFFFFFFF8, 32'h0,    32'h30};
    pcs[1] = '{32'h1000,     32'h100,      32'h10,       32'h1004, 32'h120};
    pcs[2] = '{32'h0,        32'h0,        32'h80000001, 32'h4,    32'h2};

    #2;
    chk("reset_result_q", result_q_o, 32'h0);
    chk("reset_zero_q", {31'b0, zero_q_o}, 32'h0);

    for (int i = 0; i < 14; i++) begin
      set_in(vecs[i].op, vecs[i].funct, vecs[i].a, vecs[i].b);
      #1;
      chk($sformatf("ctrl[%0d]", i), {29'b0, ALUCtrl_o}, {29'b0, vecs[i].ctrl});
      chk($sformatf("data[%0d]", i), data_o, vecs[i].res);
      chk($sformatf("zero[%0d]", i), {31'b0, Zero_o}, {31'b0, vecs[i].zero});
    end

    for (int i = 0; i < 3; i++) begin
      pc_i = pcs[i].pc;
      pc_id_i = pcs[i].pc_id;
      imm_i = pcs[i].imm;
      #1;
      chk($sformatf("pc_plus4[%0d]", i), pc_plus4_o, pcs[i].plus4);
      chk($sformatf("branch_target[%0d]", i), branch_target_o, pcs[i].target);
    end

    set_in(2'b00, 10'b0, 32'hAB, 32'h0);
    step();
    chk("held_in_reset", result_q_o, 32'h0);
    #3 rst_i = 1'b1;
    #1;
    chk("release_waits_edge", result_q_o, 32'h0);
    step();
    chk("load_ab", result_q_o, 32'hAB);
    chk("load_ab_zero", {31'b0, zero_q_o}, 32'h0);

    stall_i = 1'b1;
    set_in(2'b01, 10'b0, 32'h5, 32'h5);
    step();
    step();
    chk("stall_hold", result_q_o, 32'hAB);
    chk("stall_hold_zero", {31'b0, zero_q_o}, 32'h0);
    chk("stall_comb_zero", {31'b0, Zero_o}, 32'h1);

    stall_i = 1'b0;
    step();
    chk("unstall_load", result_q_o, 32'h0);
    chk("unstall_zero", {31'b0, zero_q_o}, 32'h1);

    set_in(2'b00, 10'b0, 32'hAB, 32'h0);
    step();
    chk("reload_ab", result_q_o, 32'hAB);
    stall_i = 1'b1;
    #2 rst_i = 1'b0;
    #1;
    chk("async_clear", result_q_o, 32'h0);
    chk("async_clear_zero", {31'b0, zero_q_o}, 32'h0);
    chk("comb_in_reset", data_o, 32'hAB);
    stall_i = 1'b0;
    step();
    chk("reset_holds", result_q_o, 32'h0);
    #2 rst_i = 1'b1;
    #1;
    chk("release_mid_cycle", result_q_o, 32'h0);
    step();
    chk("after_release", result_q_o, 32'hAB);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
